// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op encoding, NZCV flag layout and datapath constants.
package alu_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        XOR = 2'b10,
        NOT = 2'b11
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    localparam int ALU_W  = 32;
    localparam int MSB    = ALU_W - 1;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/ALUConFlags.sv
// ALUConFlags: 32-bit combinational ALU producing NZCV flags.
//   a_i, b_i  operands
//   op_i      ADD / SUB / XOR / NOT (NOT inverts a_i)
//   result_o  result
//   flags_o   NZCV; C and V are forced to 0 for XOR and NOT
module ALUConFlags
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a_i,
    input  logic [ALU_W-1:0] b_i,
    input  alu_op_t          op_i,
    output logic [ALU_W-1:0] result_o,
    output nzcv_t            flags_o
);

    logic             sub;
    logic [ALU_W-1:0] b_eff;
    logic [ALU_W:0]   sum;

    // SUB is a + ~b + 1, so C is the ARM-style "no borrow" flag.
    always_comb begin
        sub      = (op_i == SUB);
        b_eff    = sub ? ~b_i : b_i;
        sum      = {1'b0, a_i} + {1'b0, b_eff} + {{ALU_W{1'b0}}, sub};
        result_o = (op_i == XOR) ? a_i ^ b_i : (op_i == NOT) ? ~a_i : sum[ALU_W-1:0];
        flags_o.n = result_o[MSB];
        flags_o.z = (result_o == '0);
        flags_o.c = !op_i[1] & sum[ALU_W];
        flags_o.v = !op_i[1] & (a_i[MSB] == b_eff[MSB]) & (sum[MSB] != a_i[MSB]);
    end

endmodule

// File: rtl/alu_rr_pick.sv
// alu_rr_pick: 2-way combinational round-robin picker.
//   valid_i  request valids, bit i = requester i
//   prio_i   requester that wins when both are valid
//   gnt_o    granted requester id (0 when nothing is valid)
//   any_o    at least one requester is valid
module alu_rr_pick (
    input  logic [1:0] valid_i,
    input  logic       prio_i,
    output logic       gnt_o,
    output logic       any_o
);

    always_comb begin
        any_o = |valid_i;
        gnt_o = (&valid_i) ? prio_i : valid_i[1];
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one flag-producing ALU between two requesters.
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid_i/ready_o   per-requester handshake
//   req_a_i/b_i/op_i      per-requester operands and op
//   req_setf_i            accepted op also writes that requester's NZCV register
//   rsp_valid_o/ready_i   single-slot response handshake
//   rsp_id_o/result_o     granted requester and ALU result, one cycle after accept
//   rsp_flags_o           NZCV of that op regardless of setf
//   flags0_o/flags1_o     architectural NZCV per requester
// N must be 32: the flag logic is hard-wired to bit 31.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid_i,
    output logic [1:0]      req_ready_o,
    input  logic [1:0][N-1:0] req_a_i,
    input  logic [1:0][N-1:0] req_b_i,
    input  logic [1:0][1:0] req_op_i,
    input  logic [1:0]      req_setf_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic            rsp_id_o,
    output logic [N-1:0]    rsp_result_o,
    output logic [3:0]      rsp_flags_o,
    output logic [3:0]      flags0_o,
    output logic [3:0]      flags1_o
);

    logic         gnt;
    logic         any;
    logic         free;
    logic         accept;
    logic [N-1:0] alu_res;
    nzcv_t        alu_fl;

    logic         rsp_valid_q, rsp_valid_d;
    logic         rsp_id_q, rsp_id_d;
    logic [N-1:0] rsp_result_q, rsp_result_d;
    nzcv_t        rsp_flags_q, rsp_flags_d;
    nzcv_t        flags0_q, flags0_d;
    nzcv_t        flags1_q, flags1_d;
    logic         prio_q, prio_d;

    alu_rr_pick u_pick (
        .valid_i (req_valid_i),
        .prio_i  (prio_q),
        .gnt_o   (gnt),
        .any_o   (any)
    );

    ALUConFlags u_alu (
        .a_i      (req_a_i[gnt]),
        .b_i      (req_b_i[gnt]),
        .op_i     (alu_op_t'(req_op_i[gnt])),
        .result_o (alu_res),
        .flags_o  (alu_fl)
    );

    // The slot refills in the same cycle it drains, giving one op per cycle.
    always_comb begin
        free         = !rsp_valid_q | rsp_ready_i;
        accept       = any & free;
        req_ready_o  = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
        rsp_valid_d  = accept | (rsp_valid_q & !rsp_ready_i);
        rsp_id_d     = accept ? gnt : rsp_id_q;
        rsp_result_d = accept ? alu_res : rsp_result_q;
        rsp_flags_d  = accept ? alu_fl : rsp_flags_q;
        flags0_d     = (accept & !gnt & req_setf_i[0]) ? alu_fl : flags0_q;
        flags1_d     = (accept & gnt & req_setf_i[1]) ? alu_fl : flags1_q;
        prio_d       = accept ? !gnt : prio_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            flags0_q     <= '0;
            flags1_q     <= '0;
            prio_q       <= 1'b0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            flags0_q     <= flags0_d;
            flags1_q     <= flags1_d;
            prio_q       <= prio_d;
        end
    end

    always_comb begin
        rsp_valid_o  = rsp_valid_q;
        rsp_id_o     = rsp_id_q;
        rsp_result_o = rsp_result_q;
        rsp_flags_o  = rsp_flags_q;
        flags0_o     = flags0_q;
        flags1_o     = flags1_q;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: self-checking bench for alu_share_arbiter.
module tb_alu_share_arbiter;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid_i;
    logic [1:0]       req_ready_o;
    logic [1:0][31:0] req_a_i;
    logic [1:0][31:0] req_b_i;
    logic [1:0][1:0]  req_op_i;
    logic [1:0]       req_setf_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic             rsp_id_o;
    logic [31:0]      rsp_result_o;
    logic [3:0]       rsp_flags_o;
    logic [3:0]       flags0_o;
    logic [3:0]       flags1_o;

    alu_share_arbiter #(.N(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .req_op_i     (req_op_i),
        .req_setf_i   (req_setf_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_result_o (rsp_result_o),
        .rsp_flags_o  (rsp_flags_o),
        .flags0_o     (flags0_o),
        .flags1_o     (flags1_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: what the response slot and flag registers must hold.
    logic        m_valid;
    int          m_id;
    logic [31:0] m_res;
    logic [3:0]  m_flags;
    logic [3:0]  m_fl [2];
    int          m_tie;   // who wins a tie: never the most recent grantee
    int          m_acc;   // requester accepted in the last step, -1 for none

    // A requester left waiting at an edge must still be valid at the next edge.
    logic [1:0] pend_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= 2'b00;
        else begin
            assert ((pend_q & ~req_valid_i) == 2'b00)
                else $error("protocol: valid dropped without handshake");
            pend_q <= req_valid_i & ~req_ready_o;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void ref_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f);
        longint sa;
        longint sb;
        longint s;
        logic   c;
        logic   v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 1'b0;
        v = 1'b0;
        case (op)
            2'd0: begin
                r = a + b;
                s = sa + sb;
                c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'd1: begin
                r = a - b;
                s = sa - sb;
                c = (a >= b);
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'd2: r = a ^ b;
            default: r = ~a;
        endcase
        f = {r[31], r == 32'd0, c, v};
    endfunction

    function automatic logic [31:0] rv();
        logic [31:0] corner [5];
        corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        return ($urandom % 4 == 0) ? corner[$urandom % 5] : $urandom;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_id    = 0;
        m_res   = '0;
        m_flags = '0;
        m_fl[0] = '0;
        m_fl[1] = '0;
        m_tie   = 0;
        m_acc   = -1;
    endtask

    // Called at a negedge with inputs already driven; checks ready before the
    // edge, advances the model, checks the registered outputs after the edge.
    task automatic step();
        int          g;
        logic [1:0]  er;
        logic [31:0] r;
        logic [3:0]  f;
        #1;
        if (req_valid_i == 2'b11) g = m_tie;
        else if (req_valid_i[1]) g = 1;
        else if (req_valid_i[0]) g = 0;
        else g = -1;
        er = (g >= 0 && (!m_valid || rsp_ready_i)) ? (g == 1 ? 2'b10 : 2'b01) : 2'b00;
        chk("ready", 32'(req_ready_o), 32'(er));
        m_acc = (er != 2'b00) ? g : -1;
        if (m_acc >= 0) begin
            ref_alu(req_op_i[g], req_a_i[g], req_b_i[g], r, f);
            m_valid = 1'b1;
            m_id    = g;
            m_res   = r;
            m_flags = f;
            if (req_setf_i[g]) m_fl[g] = f;
            m_tie   = 1 - g;
        end else if (rsp_ready_i) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("rsp_valid", 32'(rsp_valid_o), 32'(m_valid));
        chk("rsp_id", 32'(rsp_id_o), 32'(m_id));
        chk("rsp_result", rsp_result_o, m_res);
        chk("rsp_flags", 32'(rsp_flags_o), 32'(m_flags));
        chk("flags0", 32'(flags0_o), 32'(m_fl[0]));
        chk("flags1", 32'(flags1_o), 32'(m_fl[1]));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid_i = 2'b00;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    typedef struct {
        int          req;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        setf;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;

    vec_t vecs [9];
    logic [3:0] tfl [2];

    initial begin
        vecs[0] = '{1, 2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 4'b0110};
        vecs[1] = '{0, 2'd2, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 32'hFFFF_FFFF, 4'b1000};
        vecs[2] = '{0, 2'd1, 32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 4'b0110};
        vecs[3] = '{0, 2'd3, 32'h0000_FFFF, 32'h1234_5678, 1'b0, 32'hFFFF_0000, 4'b1000};
        vecs[4] = '{1, 2'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 4'b1001};
        vecs[5] = '{1, 2'd1, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 4'b1000};
        vecs[6] = '{0, 2'd1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b0011};
        vecs[7] = '{1, 2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 4'b0111};
        vecs[8] = '{0, 2'd2, 32'hAAAA_5555, 32'hAAAA_5555, 1'b1, 32'h0000_0000, 4'b0100};

        rst_n = 1'b0;
        req_valid_i = 2'b00;
        req_a_i = '0;
        req_b_i = '0;
        req_op_i = '0;
        req_setf_i = 2'b00;
        rsp_ready_i = 1'b1;
        model_reset();
        do_reset();

        #1;
        chk("reset rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("reset rsp_id", 32'(rsp_id_o), 32'd0);
        chk("reset rsp_result", rsp_result_o, 32'd0);
        chk("reset rsp_flags", 32'(rsp_flags_o), 32'd0);
        chk("reset flags0", 32'(flags0_o), 32'd0);
        chk("reset flags1", 32'(flags1_o), 32'd0);
        @(negedge clk);

        // Directed single-requester ops against hand-computed results.
        tfl[0] = 4'b0000;
        tfl[1] = 4'b0000;
        for (int i = 0; i < 9; i++) begin
            req_a_i = {$urandom, $urandom};
            req_b_i = {$urandom, $urandom};
            req_op_i = 4'($urandom);
            req_setf_i = 2'($urandom);
            req_a_i[vecs[i].req] = vecs[i].a;
            req_b_i[vecs[i].req] = vecs[i].b;
            req_op_i[vecs[i].req] = vecs[i].op;
            req_setf_i[vecs[i].req] = vecs[i].setf;
            req_valid_i = (vecs[i].req == 1) ? 2'b10 : 2'b01;
            rsp_ready_i = 1'b1;
            step();
            if (vecs[i].setf) tfl[vecs[i].req] = vecs[i].fl;
            chk($sformatf("vec%0d id", i), 32'(rsp_id_o), 32'(vecs[i].req));
            chk($sformatf("vec%0d result", i), rsp_result_o, vecs[i].res);
            chk($sformatf("vec%0d flags", i), 32'(rsp_flags_o), 32'(vecs[i].fl));
            chk($sformatf("vec%0d flags0", i), 32'(flags0_o), 32'(tfl[0]));
            chk($sformatf("vec%0d flags1", i), 32'(flags1_o), 32'(tfl[1]));
            req_valid_i = 2'b00;
        end
        step();
        chk("drain rsp_valid", 32'(rsp_valid_o), 32'd0);

        // Alternation under continuous ties, starting from a fresh reset.
        do_reset();
        req_op_i = {2'd1, 2'd1};
        req_setf_i = 2'b11;
        for (int i = 0; i < 2; i++) begin
            req_a_i[i] = $urandom;
            req_b_i[i] = req_a_i[i];
        end
        req_valid_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("alt%0d ready", k), 32'(req_ready_o), (k % 2) ? 32'd2 : 32'd1);
            step();
            chk($sformatf("alt%0d id", k), 32'(rsp_id_o), 32'(k % 2));
            chk($sformatf("alt%0d result", k), rsp_result_o, 32'd0);
            chk($sformatf("alt%0d flags", k), 32'(rsp_flags_o), 32'b0110);
            if (m_acc >= 0) begin
                req_a_i[m_acc] = $urandom;
                req_b_i[m_acc] = req_a_i[m_acc];
            end
        end

        // Stall with both waiting, then release: drain and accept in one edge.
        rsp_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d ready", k), 32'(req_ready_o), 32'd0);
            step();
            chk($sformatf("stall%0d id", k), 32'(rsp_id_o), 32'd1);
            chk($sformatf("stall%0d valid", k), 32'(rsp_valid_o), 32'd1);
        end
        rsp_ready_i = 1'b1;
        #1;
        chk("release ready", 32'(req_ready_o), 32'd1);
        step();
        chk("release valid", 32'(rsp_valid_o), 32'd1);
        chk("release id", 32'(rsp_id_o), 32'd0);
        req_valid_i = 2'b10;
        step();
        chk("post-release id", 32'(rsp_id_o), 32'd1);
        req_valid_i = 2'b00;
        step();

        // Reset while a response is stalled.
        req_op_i[0] = 2'd1;
        req_setf_i[0] = 1'b1;
        req_a_i[0] = 32'd9;
        req_b_i[0] = 32'd9;
        req_valid_i = 2'b01;
        rsp_ready_i = 1'b0;
        step();
        req_valid_i = 2'b11;
        step();
        chk("pre-reset flags0", 32'(flags0_o), 32'b0110);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("async flags0", 32'(flags0_o), 32'd0);
        chk("async flags1", 32'(flags1_o), 32'd0);
        chk("async result", rsp_result_o, 32'd0);
        req_valid_i = 2'b00;
        rsp_ready_i = 1'b1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req_valid_i = 2'b11;
        step();
        chk("post-reset tie id", 32'(rsp_id_o), 32'd0);
        req_valid_i = 2'b10;
        step();
        req_valid_i = 2'b00;
        step();

        // Random traffic; a request is held until it is accepted.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid_i[i] && ($urandom % 2 == 0)) begin
                    req_a_i[i] = rv();
                    req_b_i[i] = ($urandom % 8 == 0) ? req_a_i[i] : rv();
                    req_op_i[i] = 2'($urandom);
                    req_setf_i[i] = 1'($urandom);
                    req_valid_i[i] = 1'b1;
                end
            end
            rsp_ready_i = ($urandom % 4) != 0;
            step();
            if (m_acc >= 0) req_valid_i[m_acc] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
